// File: rtl/game_draw_sequencer.sv
// game_draw_sequencer: master control FSM for the game. Sequences the title, stage and
// win-screen loads, then runs the per-frame render loop (tiles, bombs, then per player
// the corner checks, sprite and HP icons). Also derives frame and refresh timing from
// the system clock.
module game_draw_sequencer #(
    parameter int NUM_PLAYERS     = 2,
    parameter int NUM_BOMBS       = 6,
    parameter int MAX_LIVES       = 3,
    parameter int CLK_DIV         = 833333,
    parameter int FRAMES_PER_TICK = 15,
    localparam int LW = $clog2(MAX_LIVES + 1),
    localparam int PW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1,
    localparam int BW = (NUM_BOMBS > 1) ? $clog2(NUM_BOMBS) : 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      go,
    input  logic                      finished,
    input  logic                      all_tiles_drawn,
    input  logic [NUM_PLAYERS*LW-1:0] lives,
    output logic [1:0]                memory_select,
    output logic                      copy_enable,
    output logic                      tc_enable,
    output logic                      player_reset,
    output logic                      tile_reset,
    output logic                      draw_stage,
    output logic                      draw_tile,
    output logic                      draw_explosion,
    output logic                      draw_bomb,
    output logic                      check_player,
    output logic                      draw_player,
    output logic                      draw_hp,
    output logic [PW-1:0]             player_id,
    output logic [BW-1:0]             bomb_id,
    output logic [LW-1:0]             hp_id,
    output logic [1:0]                corner_id,
    output logic                      print_screen,
    output logic                      refresh,
    output logic [PW-1:0]             winner,
    output logic                      winner_valid
);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int RW = (FRAMES_PER_TICK > 1) ? $clog2(FRAMES_PER_TICK) : 1;

    localparam logic [4:0] S_LOAD_TITLE   = 5'd0;
    localparam logic [4:0] S_TITLE        = 5'd1;
    localparam logic [4:0] S_LOAD_STAGE   = 5'd2;
    localparam logic [4:0] S_DRAW_TILE    = 5'd3;
    localparam logic [4:0] S_DRAW_EXPL    = 5'd4;
    localparam logic [4:0] S_NEXT_TILE    = 5'd5;
    localparam logic [4:0] S_DRAW_BOMB    = 5'd6;
    localparam logic [4:0] S_NEXT_BOMB    = 5'd7;
    localparam logic [4:0] S_PLAYER_START = 5'd8;
    localparam logic [4:0] S_CHECK_CORNER = 5'd9;
    localparam logic [4:0] S_NEXT_CORNER  = 5'd10;
    localparam logic [4:0] S_DRAW_PLAYER  = 5'd11;
    localparam logic [4:0] S_DRAW_HP      = 5'd12;
    localparam logic [4:0] S_NEXT_HP      = 5'd13;
    localparam logic [4:0] S_NEXT_PLAYER  = 5'd14;
    localparam logic [4:0] S_IDLE         = 5'd15;
    localparam logic [4:0] S_UPDATE       = 5'd16;
    localparam logic [4:0] S_LOAD_WIN     = 5'd17;
    localparam logic [4:0] S_WIN          = 5'd18;

    logic [4:0]    state;
    logic [4:0]    state_next;
    logic [DW-1:0] div_cnt;
    logic [RW-1:0] ref_cnt;
    logic          frame_active;
    logic          frame_tick;
    logic [LW-1:0] lives_cur;
    logic [PW:0]   alive_cnt;
    logic [PW-1:0] winner_next;
    logic          game_over;
    logic          bomb_last;
    logic          hp_last;
    logic          player_last;

    // The divider only runs while the game loop is on screen (DRAW_TILE through UPDATE).
    assign frame_active = (state >= S_DRAW_TILE) && (state <= S_UPDATE);
    assign frame_tick   = frame_active && (div_cnt == DW'(CLK_DIV - 1));
    assign bomb_last    = (bomb_id == BW'(NUM_BOMBS - 1));
    assign player_last  = (player_id == PW'(NUM_PLAYERS - 1));
    // lives==0 never reaches DRAW_HP, so the LW-bit wrap of lives-1 is harmless.
    assign hp_last      = (hp_id == (lives_cur - LW'(1)));
    assign game_over    = (alive_cnt <= (PW+1)'(1));

    // Per-player lives lookup, alive count and lowest-index surviving player.
    always_comb begin
        lives_cur   = '0;
        alive_cnt   = '0;
        winner_next = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (player_id == PW'(p))
                lives_cur = lives[p*LW +: LW];
            if (lives[p*LW +: LW] != '0)
                alive_cnt = alive_cnt + (PW+1)'(1);
        end
        for (int p = NUM_PLAYERS - 1; p >= 0; p--) begin
            if (lives[p*LW +: LW] != '0)
                winner_next = PW'(p);
        end
    end

    // Next-state logic for the load / render / update sequence.
    always_comb begin
        state_next = state;
        case (state)
            S_LOAD_TITLE:   if (finished) state_next = S_TITLE;
            S_TITLE:        if (go) state_next = S_LOAD_STAGE;
            S_LOAD_STAGE:   if (finished) state_next = S_DRAW_TILE;
            S_DRAW_TILE:    if (finished) state_next = S_DRAW_EXPL;
            S_DRAW_EXPL:    if (finished) state_next = S_NEXT_TILE;
            S_NEXT_TILE:    state_next = all_tiles_drawn ? S_DRAW_BOMB : S_DRAW_TILE;
            S_DRAW_BOMB:    if (finished) state_next = S_NEXT_BOMB;
            S_NEXT_BOMB:    state_next = bomb_last ? S_PLAYER_START : S_DRAW_BOMB;
            S_PLAYER_START: state_next = S_CHECK_CORNER;
            S_CHECK_CORNER: state_next = S_NEXT_CORNER;
            S_NEXT_CORNER:  state_next = (corner_id == 2'd3) ? S_DRAW_PLAYER : S_CHECK_CORNER;
            S_DRAW_PLAYER:  if (finished) state_next = (lives_cur == '0) ? S_NEXT_PLAYER : S_DRAW_HP;
            S_DRAW_HP:      if (finished) state_next = S_NEXT_HP;
            S_NEXT_HP:      state_next = hp_last ? S_NEXT_PLAYER : S_DRAW_HP;
            S_NEXT_PLAYER:  state_next = player_last ? S_IDLE : S_PLAYER_START;
            S_IDLE:         if (frame_tick) state_next = S_UPDATE;
            S_UPDATE: begin
                if (game_over)
                    state_next = S_LOAD_WIN;
                else if (finished)
                    state_next = S_DRAW_TILE;
            end
            S_LOAD_WIN:     if (finished) state_next = S_WIN;
            S_WIN:          if (go) state_next = S_LOAD_TITLE;
            default:        state_next = S_LOAD_TITLE;
        endcase
    end

    // State register; reset aborts whatever frame is in progress.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= S_LOAD_TITLE;
        else
            state <= state_next;
    end

    // Object index counters for bombs, players, corners and HP icons.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bomb_id   <= '0;
            player_id <= '0;
            hp_id     <= '0;
            corner_id <= '0;
        end else begin
            case (state)
                S_LOAD_STAGE: begin
                    bomb_id   <= '0;
                    player_id <= '0;
                    hp_id     <= '0;
                    corner_id <= '0;
                end
                S_NEXT_BOMB:    bomb_id <= bomb_last ? '0 : bomb_id + BW'(1);
                S_PLAYER_START: begin
                    corner_id <= '0;
                    hp_id     <= '0;
                end
                S_NEXT_CORNER:  corner_id <= corner_id + 2'd1;
                S_NEXT_HP:      hp_id <= hp_last ? '0 : hp_id + LW'(1);
                S_NEXT_PLAYER:  player_id <= player_last ? '0 : player_id + PW'(1);
                default: ;
            endcase
        end
    end

    // Frame divider and refresh counter; refresh is a registered pulse on refresh wrap.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
            ref_cnt <= '0;
            refresh <= 1'b0;
        end else begin
            refresh <= 1'b0;
            if (state == S_LOAD_STAGE) begin
                div_cnt <= '0;
                ref_cnt <= '0;
            end else if (frame_active) begin
                if (frame_tick) begin
                    div_cnt <= '0;
                    if (ref_cnt == RW'(FRAMES_PER_TICK - 1)) begin
                        ref_cnt <= '0;
                        refresh <= 1'b1;
                    end else begin
                        ref_cnt <= ref_cnt + RW'(1);
                    end
                end else begin
                    div_cnt <= div_cnt + DW'(1);
                end
            end
        end
    end

    // Winner is captured on entry to the win screen and held until the next stage load.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            winner       <= '0;
            winner_valid <= 1'b0;
        end else if ((state == S_UPDATE) && game_over) begin
            winner       <= winner_next;
            winner_valid <= (alive_cnt == (PW+1)'(1));
        end else if (state == S_LOAD_STAGE) begin
            winner       <= '0;
            winner_valid <= 1'b0;
        end
    end

    // Moore decode of datapath strobes and memory select.
    always_comb begin
        memory_select  = 2'd0;
        copy_enable    = 1'b0;
        tc_enable      = 1'b0;
        player_reset   = 1'b0;
        tile_reset     = 1'b0;
        draw_stage     = 1'b0;
        draw_tile      = 1'b0;
        draw_explosion = 1'b0;
        draw_bomb      = 1'b0;
        check_player   = 1'b0;
        draw_player    = 1'b0;
        draw_hp        = 1'b0;
        print_screen   = 1'b0;
        case (state)
            S_LOAD_TITLE: begin
                copy_enable = 1'b1;
                draw_stage  = 1'b1;
            end
            S_LOAD_STAGE: begin
                memory_select = 2'd1;
                copy_enable   = 1'b1;
                draw_stage    = 1'b1;
                player_reset  = 1'b1;
                tile_reset    = 1'b1;
            end
            S_DRAW_TILE: begin
                memory_select = 2'd3;
                copy_enable   = 1'b1;
                draw_tile     = 1'b1;
            end
            S_DRAW_EXPL: begin
                memory_select  = 2'd3;
                copy_enable    = 1'b1;
                draw_explosion = 1'b1;
            end
            S_NEXT_TILE: tc_enable = 1'b1;
            S_DRAW_BOMB: begin
                memory_select = 2'd3;
                copy_enable   = 1'b1;
                draw_bomb     = 1'b1;
            end
            S_CHECK_CORNER: begin
                memory_select = 2'd3;
                check_player  = 1'b1;
            end
            S_DRAW_PLAYER: begin
                memory_select = 2'd3;
                copy_enable   = 1'b1;
                draw_player   = 1'b1;
            end
            S_DRAW_HP: begin
                memory_select = 2'd3;
                copy_enable   = 1'b1;
                draw_hp       = 1'b1;
            end
            S_UPDATE: print_screen = 1'b1;
            S_LOAD_WIN: begin
                memory_select = 2'd2;
                copy_enable   = 1'b1;
                draw_stage    = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_game_draw_sequencer.sv
// Testbench for game_draw_sequencer: a 2-player instance with a short frame divider,
// plus a 4-player instance for the player iteration scenario.
module tb_game_draw_sequencer;
    logic       clock = 1'b0;
    logic       reset;
    logic       go;
    logic       finished;
    logic       all_tiles_drawn;
    logic [3:0] lives;
    logic [1:0] memory_select;
    logic       copy_enable, tc_enable, player_reset, tile_reset;
    logic       draw_stage, draw_tile, draw_explosion, draw_bomb;
    logic       check_player, draw_player, draw_hp, print_screen, refresh;
    logic [0:0] player_id;
    logic [2:0] bomb_id;
    logic [1:0] hp_id;
    logic [1:0] corner_id;
    logic [0:0] winner;
    logic       winner_valid;

    logic       go4, finished4, atd4;
    logic [7:0] lives4;
    logic [1:0] ms4;
    logic       ce4, tc4, pr4, tr4, ds4, dt4, de4, db4, cp4, dp4, dh4, ps4, rf4;
    logic [1:0] player_id4;
    logic [0:0] bomb_id4;
    logic [1:0] hp_id4;
    logic [1:0] corner_id4;
    logic [1:0] winner4;
    logic       wv4;

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    int ntiles = 3;
    int tiles_seen = 0;
    int exp_q[$];

    always #5 clock = ~clock;

    game_draw_sequencer #(.NUM_PLAYERS(2), .NUM_BOMBS(6), .MAX_LIVES(3),
                          .CLK_DIV(10), .FRAMES_PER_TICK(3)) dut (
        .clock(clock), .reset(reset), .go(go), .finished(finished),
        .all_tiles_drawn(all_tiles_drawn), .lives(lives),
        .memory_select(memory_select), .copy_enable(copy_enable), .tc_enable(tc_enable),
        .player_reset(player_reset), .tile_reset(tile_reset), .draw_stage(draw_stage),
        .draw_tile(draw_tile), .draw_explosion(draw_explosion), .draw_bomb(draw_bomb),
        .check_player(check_player), .draw_player(draw_player), .draw_hp(draw_hp),
        .player_id(player_id), .bomb_id(bomb_id), .hp_id(hp_id), .corner_id(corner_id),
        .print_screen(print_screen), .refresh(refresh), .winner(winner),
        .winner_valid(winner_valid));

    game_draw_sequencer #(.NUM_PLAYERS(4), .NUM_BOMBS(2), .MAX_LIVES(3),
                          .CLK_DIV(10), .FRAMES_PER_TICK(3)) dut4 (
        .clock(clock), .reset(reset), .go(go4), .finished(finished4),
        .all_tiles_drawn(atd4), .lives(lives4),
        .memory_select(ms4), .copy_enable(ce4), .tc_enable(tc4),
        .player_reset(pr4), .tile_reset(tr4), .draw_stage(ds4),
        .draw_tile(dt4), .draw_explosion(de4), .draw_bomb(db4),
        .check_player(cp4), .draw_player(dp4), .draw_hp(dh4),
        .player_id(player_id4), .bomb_id(bomb_id4), .hp_id(hp_id4), .corner_id(corner_id4),
        .print_screen(ps4), .refresh(rf4), .winner(winner4), .winner_valid(wv4));

    function automatic int ev(int kind, int pid, int idx);
        return kind * 256 + pid * 16 + idx;
    endfunction

    // Event code for the 2-player instance: 1 bomb, 2 check, 3 player, 4 hp, 5 tile, 6 expl, 7 print.
    function automatic int obs_main();
        if (draw_tile)      return ev(5, 0, 0);
        if (draw_explosion) return ev(6, 0, 0);
        if (draw_bomb)      return ev(1, 0, int'(bomb_id));
        if (check_player)   return ev(2, int'(player_id), int'(corner_id));
        if (draw_player)    return ev(3, int'(player_id), 0);
        if (draw_hp)        return ev(4, int'(player_id), int'(hp_id));
        if (print_screen)   return ev(7, int'(player_id), 0);
        return 0;
    endfunction

    function automatic int obs_four();
        if (dp4) return ev(3, int'(player_id4), 0);
        if (dh4) return ev(4, int'(player_id4), int'(hp_id4));
        if (ps4) return ev(7, int'(player_id4), 0);
        return 0;
    endfunction

    // Advance one clock, sample after the edge, and model the datapath tile counter.
    task automatic step();
        @(posedge clock);
        #1;
        if (tile_reset || print_screen) tiles_seen = 0;
        else if (draw_tile) tiles_seen++;
        all_tiles_drawn = (tiles_seen >= ntiles);
    endtask

    task automatic test_reset();
        reset = 1'b1; go = 1'b0; finished = 1'b0; all_tiles_drawn = 1'b0; lives = 4'b0101;
        go4 = 1'b0; finished4 = 1'b0; atd4 = 1'b1; lives4 = 8'h55;
        #1;
        step();
        checks++; if (memory_select !== 2'd0) begin fails++; $display("FAIL reset_memsel got %0d want 0", memory_select); end else passes++;
        checks++; if (copy_enable !== 1'b1) begin fails++; $display("FAIL reset_copy got %b want 1", copy_enable); end else passes++;
        checks++; if (draw_stage !== 1'b1) begin fails++; $display("FAIL reset_draw_stage got %b want 1", draw_stage); end else passes++;
        checks++;
        if ({tc_enable, player_reset, tile_reset, draw_tile, draw_explosion, draw_bomb,
             check_player, draw_player, draw_hp, print_screen, refresh, winner_valid} !== 12'd0) begin
            fails++; $display("FAIL reset_strobes got %b want 0", {tc_enable, player_reset, tile_reset, draw_tile,
                     draw_explosion, draw_bomb, check_player, draw_player, draw_hp, print_screen, refresh, winner_valid});
        end else passes++;
        checks++; if ({player_id, bomb_id, hp_id, corner_id, winner} !== 9'd0) begin fails++; $display("FAIL reset_ids got %b want 0", {player_id, bomb_id, hp_id, corner_id, winner}); end else passes++;
        reset = 1'b0;
    endtask

    task automatic test_boot();
        int pulses;
        step();
        checks++; if (copy_enable !== 1'b1 || draw_stage !== 1'b1) begin fails++; $display("FAIL boot_hold_title got ce=%b ds=%b want 1 1", copy_enable, draw_stage); end else passes++;
        finished = 1'b1;
        step();
        finished = 1'b0;
        checks++; if (copy_enable !== 1'b0 || draw_stage !== 1'b0) begin fails++; $display("FAIL boot_title got ce=%b ds=%b want 0 0", copy_enable, draw_stage); end else passes++;
        pulses = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (refresh) pulses++;
        end
        checks++; if (pulses !== 0) begin fails++; $display("FAIL title_divider_frozen got %0d refresh pulses want 0", pulses); end else passes++;
        go = 1'b1;
        step();
        go = 1'b0;
        checks++; if (memory_select !== 2'd1) begin fails++; $display("FAIL load_stage_memsel got %0d want 1", memory_select); end else passes++;
        checks++; if ({player_reset, tile_reset, copy_enable} !== 3'b111) begin fails++; $display("FAIL load_stage_strobes got %b want 111", {player_reset, tile_reset, copy_enable}); end else passes++;
        finished = 1'b1;
    endtask

    task automatic test_frame();
        int got, want;
        lives = 4'b0011;
        exp_q.delete();
        for (int t = 0; t < ntiles; t++) begin exp_q.push_back(ev(5, 0, 0)); exp_q.push_back(ev(6, 0, 0)); end
        for (int b = 0; b < 6; b++) exp_q.push_back(ev(1, 0, b));
        for (int c = 0; c < 4; c++) exp_q.push_back(ev(2, 0, c));
        exp_q.push_back(ev(3, 0, 0));
        for (int h = 0; h < 3; h++) exp_q.push_back(ev(4, 0, h));
        for (int c = 0; c < 4; c++) exp_q.push_back(ev(2, 1, c));
        exp_q.push_back(ev(3, 1, 0));
        exp_q.push_back(ev(7, 0, 0));
        for (int c = 0; c < 300 && exp_q.size() > 0; c++) begin
            step();
            got = obs_main();
            if (got != 0) begin
                want = exp_q.pop_front();
                checks++; if (got !== want) begin fails++; $display("FAIL frame_event got %0h want %0h", got, want); end else passes++;
                if (draw_tile) begin
                    checks++; if (memory_select !== 2'd3) begin fails++; $display("FAIL render_memsel got %0d want 3", memory_select); end else passes++;
                end
            end
        end
        checks++; if (exp_q.size() !== 0) begin fails++; $display("FAIL frame_budget got %0d events pending want 0", exp_q.size()); end else passes++;
        lives = 4'b0101;
    endtask

    task automatic test_refresh();
        int n;
        n = 0;
        while (!refresh && n < 200) begin step(); n++; end
        checks++; if (!refresh) begin fails++; $display("FAIL refresh_first got none in %0d cycles want pulse", n); end else passes++;
        for (int k = 0; k < 2; k++) begin
            n = 0;
            do begin step(); n++; end while (!refresh && n < 100);
            checks++; if (n !== 30) begin fails++; $display("FAIL refresh_period got %0d want 30", n); end else passes++;
        end
    endtask

    task automatic test_game_over();
        int n;
        lives = 4'b1000;
        n = 0;
        while (!print_screen && n < 300) begin step(); n++; end
        checks++; if (!print_screen) begin fails++; $display("FAIL gameover_update got timeout want print_screen"); end else passes++;
        step();
        checks++; if (memory_select !== 2'd2 || copy_enable !== 1'b1) begin fails++; $display("FAIL load_win got ms=%0d ce=%b want 2 1", memory_select, copy_enable); end else passes++;
        checks++; if (winner !== 1'b1 || winner_valid !== 1'b1) begin fails++; $display("FAIL winner_single got w=%0d v=%b want 1 1", winner, winner_valid); end else passes++;
        step();
        checks++; if (copy_enable !== 1'b0 || winner !== 1'b1) begin fails++; $display("FAIL win_hold got ce=%b w=%0d want 0 1", copy_enable, winner); end else passes++;
        go = 1'b1;
        lives = 4'b0000;
        step();
        checks++; if (draw_stage !== 1'b1 || memory_select !== 2'd0 || winner_valid !== 1'b1) begin fails++; $display("FAIL win_to_title got ds=%b ms=%0d v=%b want 1 0 1", draw_stage, memory_select, winner_valid); end else passes++;
        step();
        step();
        checks++; if (memory_select !== 2'd1 || player_reset !== 1'b1) begin fails++; $display("FAIL go_level_restart got ms=%0d pr=%b want 1 1", memory_select, player_reset); end else passes++;
        go = 1'b0;
        step();
        checks++; if (winner_valid !== 1'b0 || winner !== 1'b0) begin fails++; $display("FAIL winner_cleared got w=%0d v=%b want 0 0", winner, winner_valid); end else passes++;
        n = 0;
        while (!print_screen && n < 300) begin step(); n++; end
        step();
        checks++; if (memory_select !== 2'd2 || winner_valid !== 1'b0) begin fails++; $display("FAIL draw_game got ms=%0d v=%b want 2 0", memory_select, winner_valid); end else passes++;
    endtask

    task automatic test_reset_mid_hp();
        int n;
        reset = 1'b1;
        step();
        reset = 1'b0;
        lives = 4'b0011;
        go = 1'b1;
        finished = 1'b1;
        n = 0;
        while (!(draw_hp && hp_id == 2'd1) && n < 300) begin step(); n++; end
        checks++; if (!(draw_hp && hp_id == 2'd1)) begin fails++; $display("FAIL reach_hp got timeout want draw_hp hp_id=1"); end else passes++;
        go = 1'b0;
        finished = 1'b0;
        #2 reset = 1'b1;
        #1;
        checks++; if (copy_enable !== 1'b1 || draw_stage !== 1'b1 || draw_hp !== 1'b0) begin fails++; $display("FAIL midhp_async got ce=%b ds=%b hp=%b want 1 1 0", copy_enable, draw_stage, draw_hp); end else passes++;
        checks++; if ({player_id, bomb_id, hp_id, corner_id} !== 8'd0) begin fails++; $display("FAIL midhp_ids got %b want 0", {player_id, bomb_id, hp_id, corner_id}); end else passes++;
        step();
        reset = 1'b0;
        step();
        checks++; if (copy_enable !== 1'b1 || memory_select !== 2'd0 || hp_id !== 2'd0) begin fails++; $display("FAIL midhp_after got ce=%b ms=%0d hp=%0d want 1 0 0", copy_enable, memory_select, hp_id); end else passes++;
    endtask

    task automatic test_four_players();
        int got, want;
        reset = 1'b1;
        go4 = 1'b1; finished4 = 1'b1; atd4 = 1'b1; lives4 = 8'h55;
        step();
        reset = 1'b0;
        exp_q.delete();
        for (int p = 0; p < 4; p++) begin exp_q.push_back(ev(3, p, 0)); exp_q.push_back(ev(4, p, 0)); end
        exp_q.push_back(ev(7, 0, 0));
        for (int c = 0; c < 400 && exp_q.size() > 0; c++) begin
            step();
            got = obs_four();
            if (got != 0) begin
                want = exp_q.pop_front();
                checks++; if (got !== want) begin fails++; $display("FAIL four_event got %0h want %0h", got, want); end else passes++;
            end
        end
        checks++; if (exp_q.size() !== 0) begin fails++; $display("FAIL four_budget got %0d events pending want 0", exp_q.size()); end else passes++;
    endtask

    initial begin
        test_reset();
        test_boot();
        test_frame();
        test_refresh();
        test_game_over();
        test_reset_mid_hp();
        test_four_players();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
